// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - FIFO-buffered issue/retire stage around the ripple ALU
// Define ALU_ISSUE_STATS_EN to compile the op_cnt/carry_cnt retire statistics.
module alu_issue_stage #(
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [31:0]                    in_a,
    input  logic [31:0]                    in_b,
    input  logic [1:0]                     in_s,
    output logic [31:0]                    alu_a,
    output logic [31:0]                    alu_b,
    output logic [1:0]                     alu_s,
    input  logic [31:0]                    alu_out,
    input  logic                           alu_cout,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [31:0]                    res_data,
    output logic                           res_cout,
    output logic [$clog2(DEPTH+1)-1:0]     fifo_count,
    output logic [15:0]                    op_cnt,
    output logic [15:0]                    carry_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   mem_a [DEPTH];
    logic [31:0]   mem_b [DEPTH];
    logic [1:0]    mem_s [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          push;
    logic          issue;

    // A full FIFO refuses pushes even when the head pops in the same cycle.
    assign full     = (fifo_count == CW'(DEPTH));
    assign empty    = (fifo_count == '0);
    assign in_ready = !full && !rst;
    assign push     = in_valid && in_ready;
    assign issue    = !empty && (!res_valid || res_ready);

    assign alu_a = empty ? '0 : mem_a[rd_ptr];
    assign alu_b = empty ? '0 : mem_b[rd_ptr];
    assign alu_s = empty ? '0 : mem_s[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= in_a;
            mem_b[wr_ptr] <= in_b;
            mem_s[wr_ptr] <= in_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_cout   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, issue})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            // Result fields only change on issue, so they hold under backpressure and after drain.
            if (issue) begin
                res_valid <= 1'b1;
                res_data  <= alu_out;
                res_cout  <= alu_cout;
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_ISSUE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            op_cnt    <= '0;
            carry_cnt <= '0;
        end else if (issue) begin
            op_cnt <= op_cnt + 16'd1;
            if (alu_cout) begin
                carry_cnt <= carry_cnt + 16'd1;
            end
        end
    end
`else
    assign op_cnt    = '0;
    assign carry_cnt = '0;
`endif

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Buffered issue/retire stage wrapped around the 32-bit ripple ALU (eight chained 4-bit slices, 2-bit select, carry out). It accepts operations from upstream on a valid/ready handshake and queues them in a small FIFO. It presents the head entry to the combinational ALU, registers the ALU result and carry, and hands the result downstream on a second valid/ready handshake. It decouples upstream issue timing from downstream consumption and isolates the long carry chain between two register boundaries.

## Interface
- DEPTH, 4, FIFO entries; power of two, 2..16
- clk  in  1  single clock, rising edge
- rst  in  1  reset: synchronous, active-high
- in_valid  in  1  upstream op valid
- in_ready  out  1  stage can accept op
- in_a  in  32  operand A
- in_b  in  32  operand B
- in_s  in  2  ALU select, passed opaque to ALU
- alu_a  out  32  to ALU A
- alu_b  out  32  to ALU B
- alu_s  out  2  to ALU s
- alu_out  in  32  from ALU OUT
- alu_cout  in  1  from ALU cout
- res_valid  out  1  result register holds data
- res_ready  in  1  downstream accepts result
- res_data  out  32  registered ALU OUT
- res_cout  out  1  registered ALU cout
- fifo_count  out  $clog2(DEPTH+1)  occupied entries
- op_cnt  out  16  retired-op counter (see Configuration)
- carry_cnt  out  16  retired ops with cout=1 (see Configuration)

## Operation
- Push: in_valid && in_ready at a clk edge writes {in_a, in_b, in_s} at the tail.
- in_ready = !full && !rst. There is no push while full, even when the head pops in the same cycle.
- Head drive: alu_a/alu_b/alu_s = head entry when fifo_count>0, else all zero. The path is combinational from storage, with no extra register.
- Issue condition: fifo_count>0 && (!res_valid || res_ready).
- On issue: pop head, res_data<=alu_out, res_cout<=alu_cout, res_valid<=1.
- Drain without issue: res_valid && res_ready && fifo_count==0 → res_valid<=0. res_data and res_cout hold their last value.
- res_data and res_cout stay stable while res_valid && !res_ready.
- Pointers are log2(DEPTH) bits and wrap naturally.
- fifo_count is +1 on push only, −1 on pop only, and unchanged on simultaneous push and pop.
- Ops retire strictly in FIFO order; no reordering or dropping.

## Timing
- Reset (rst high at an edge) sets:
  - fifo_count=0 and pointers=0
  - res_valid=0, res_data=0, res_cout=0
  - op_cnt=0, carry_cnt=0
- Reset mid-operation discards all queued ops and any pending result. in_ready is low for the reset cycle.
- Latency: op pushed at edge E0 is issued at edge E1 if the result register is free. res_valid is high from E1 onward, i.e. 2 cycles from in_valid to res_valid.
- Throughput: 1 op/cycle sustained when res_ready is held high.
- Backpressure: with res_ready low the FIFO fills. in_ready drops the cycle after fifo_count reaches DEPTH, and the stage then holds DEPTH+1 ops in total.
- The ALU carry chain must settle within one clk period (head register → ALU → result register).

## Configuration
- ALU_ISSUE_STATS_EN defined:
  - op_cnt increments on every issue.
  - carry_cnt increments on every issue with alu_cout=1.
  - Both are 16-bit and wrap 0xFFFF→0x0000.
- ALU_ISSUE_STATS_EN undefined:
  - Counter logic is not compiled.
  - op_cnt and carry_cnt are tied to 0. Ports remain.

## Test plan
Bench ALU model: alu_out=alu_a^alu_b, alu_cout=alu_a[31]&alu_b[31].
- Single op, res_ready=1: push A=32'h0000_00F0, B=32'h0000_000F, s=0 → res_valid two cycles later with res_data=32'h0000_00FF, res_cout=0, fifo_count back to 0.
- Back-to-back stream of 8 ops, A=i, B=32'h8000_0000 → 8 results in order, one per cycle, res_data=32'h8000_0000|i, no bubbles.
- Backpressure, DEPTH=4, res_ready=0, push 6 ops:
  - 5 accepted, in_ready low after the 5th, fifo_count=4.
  - res_data holds the first result stable.
  - Release res_ready → remaining 4 retire in order.
- Wrap/simultaneous: keep occupancy at 2 with push and pop every cycle for 20 cycles → fifo_count constant 2, no lost or duplicated ops.
- Reset mid-stream with 3 queued and res_valid=1 → next cycle fifo_count=0, res_valid=0, res_data=0, in_ready=1.
- Stats (macro on): 4 ops with A=B=32'h8000_0000 (cout=1) plus 2 with A=B=0 → op_cnt=6, carry_cnt=4. Preload the counter to 0xFFFF via 65535 ops, one more → op_cnt=0. Macro off → both remain 0.
